// File: rtl/mem_access_unit_pkg.sv
// Shared widths and state encoding for the MEM-stage data-memory access unit.
package mem_access_unit_pkg;

    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the access unit (master) and data memory (slave).
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic                bus_req;
    logic                bus_we;
    logic [ADDR_LEN-1:0] bus_addr;
    logic [DATA_LEN-1:0] bus_wdata;
    logic                bus_ack;
    logic [DATA_LEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: issues one bus request per access, stalls the
// pipeline until ack, and flags misaligned addresses or ack timeouts on mem_err.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] alu_result_mem,
    input  logic [DATA_LEN-1:0] write_data_mem,
    input  logic                mem_read_flag_mem,
    input  logic                mem_write_flag_mem,
    mem_access_unit_if.master   bus,
    output logic [DATA_LEN-1:0] mem_read_data,
    output logic                stall_mem,
    output logic                mem_err
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [7:0]          wait_cnt_q, wait_cnt_d;

    logic access;
    assign access = mem_read_flag_mem | mem_write_flag_mem;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        data_d     = data_q;
        wait_cnt_d = wait_cnt_q;
        stall_mem  = 1'b0;
        mem_err    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (access) begin
                    stall_mem = 1'b1;
                    if (alu_result_mem[1:0] == 2'b00) begin
                        addr_d     = alu_result_mem;
                        wdata_d    = write_data_mem;
                        we_d       = mem_write_flag_mem;  // load+store together counts as a store
                        wait_cnt_d = '0;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_REQ: begin
                stall_mem = 1'b1;
                if (bus.bus_ack) begin
                    if (!we_q) data_d = bus.bus_rdata;
                    state_d = ST_DONE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                mem_err = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the reset clears all control and
    // data registers, so bus outputs fall asynchronously with rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            data_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            data_q     <= data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.bus_req   = (state_q == ST_REQ);
    assign bus.bus_we    = (state_q == ST_REQ) & we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign mem_read_data = (state_q == ST_ERR) ? '0 : data_q;

endmodule
